uart_result_tx: RTL and testbench
=================================

UART_RESULT_TX -- requirements
Module: uart_result_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, meaning clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the packet header byte.
REQ-003 SHALL have port clk  input  1  system clock; one clock only.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port result_valid  input  1  classification result offered.
REQ-006 SHALL have port result  input  4  digit 0..9, or 10..15 for "no decision".
REQ-007 SHALL have port train  input  1  result came from a training pass.
REQ-008 SHALL have port result_ready  output  1  block accepts a result this cycle.
REQ-009 SHALL have port tx  output  1  UART serial line, idle high.
REQ-010 SHALL have port busy  output  1  packet in flight.
REQ-011 SHALL have port done  output  1  one-cycle pulse at the end of the packet.

Function
REQ-012 SHALL send each accepted result as a 3-byte packet: B0=SYNC_BYTE, B1={3'b000, train, result}, B2=B0^B1.
REQ-013 SHALL frame every byte 8N1: start bit 0, eight data bits LSB first, stop bit 1; each bit held exactly CLK_DIV cycles.
REQ-014 SHALL send bytes back to back with no idle gap, so one packet takes 30*CLK_DIV cycles.
REQ-015 SHALL use packet FSM states IDLE -> SEND_B0 -> SEND_B1 -> SEND_B2 -> IDLE, advancing on the byte serializer's byte_done.
REQ-016 SHALL use bit FSM states IDLE, START, DATA, STOP; DATA uses a 3-bit index 0..7 and STOP -> IDLE after CLK_DIV cycles.
REQ-017 SHALL assert result_ready only in packet state IDLE; a handshake occurs when result_valid && result_ready.
REQ-018 SHALL latch result and train on the handshake edge and ignore later input changes until the packet completes.
REQ-019 SHALL drive the B0 start bit (tx=0) in the cycle after the handshake; latency from handshake to first tx fall is 1 cycle.
REQ-020 SHALL assert busy from the cycle after the handshake until the last stop-bit cycle, inclusive.
REQ-021 SHALL pulse done for exactly one cycle, the cycle after the B2 stop bit ends; busy=0 and result_ready=1 in that same cycle.
REQ-022 SHALL accept a new result in the done cycle, giving a minimum inter-packet gap of 1 cycle of tx high.
REQ-023 SHALL transmit result values 10..15 unmodified; no error path exists.
REQ-024 SHALL use a baud counter wide enough for CLK_DIV-1 that wraps to 0 at every bit boundary, with no cumulative drift.
REQ-025 SHALL treat result_valid held high across packets as successive independent requests.

Reset
REQ-026 SHALL, with rst high, set tx=1, result_ready=0, busy=0, done=0, both FSMs to IDLE and all counters to 0.
REQ-027 SHALL set result_ready=1 in the first cycle after rst deasserts.
REQ-028 SHALL abort a packet when rst is asserted mid-packet: tx=1 at the next edge, partial packet discarded, no done pulse.

Structure
REQ-029 SHALL place the SYNC_BYTE default, a packet-length constant of 3, and the packet/bit FSM state enums in the shared package uart_pkg.
REQ-030 SHALL instantiate one sub-module, uart_tx_byte (ports clk, rst, start, data[7:0], tx, byte_done), parameterized by CLK_DIV.
REQ-031 SHALL register tx as a flop output with no combinational path from inputs to tx.

Verification (CLK_DIV=4 unless noted)
REQ-032 SHALL cover: result=7, train=0, one handshake -> tx bytes 0xA5, 0x07, 0xA2; 120 cycles busy; one done pulse.
REQ-033 SHALL cover: result=3, train=1 -> bytes 0xA5, 0x13, 0xB6; each bit exactly 4 cycles wide.
REQ-034 SHALL cover: result_valid held high with result=9 -> two packets (0xA5, 0x09, 0xAC) separated by exactly 1 idle-high cycle.
REQ-035 SHALL cover: result changed to 2 mid-packet after handshake with 5 -> packet still carries 0x05 and checksum 0xA0.
REQ-036 SHALL cover: rst pulsed at cycle 50 of a packet -> tx=1 the next cycle, no done, result_ready=1 the cycle after rst drops.
REQ-037 SHALL cover: CLK_DIV=868, result=0 -> packet spans 26040 cycles; first start bit 1 cycle after the handshake.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and the packet checksum helper for the
// classification-result UART transmitter.
package uart_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned PKT_LEN           = 3;

    typedef enum logic [1:0] {
        PKT_IDLE    = 2'd0,
        PKT_SEND_B0 = 2'd1,
        PKT_SEND_B1 = 2'd2,
        PKT_SEND_B2 = 2'd3
    } pkt_state_e;

    typedef enum logic [1:0] {
        BIT_IDLE  = 2'd0,
        BIT_START = 2'd1,
        BIT_DATA  = 2'd2,
        BIT_STOP  = 2'd3
    } bit_state_e;

    function automatic logic [7:0] pkt_checksum(input logic [7:0] b0, input logic [7:0] b1);
        return b0 ^ b1;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start request during the final stop-bit cycle chains
// the next byte with no idle gap; byte_done marks that final stop-bit cycle.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam logic [15:0] LAST_CNT = 16'(CLK_DIV - 1);

    bit_state_e  state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [2:0]  idx_r, idx_s;
    logic [7:0]  shift_r, shift_s;
    logic        tx_r, tx_s;
    logic        bit_end_s;

    assign bit_end_s = (cnt_r == LAST_CNT);
    assign byte_done = (state_r == BIT_STOP) && bit_end_s;
    assign tx        = tx_r;

    // Next-state, counter and next line level of the bit sequencer
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + 16'd1;
        idx_s   = idx_r;
        shift_s = shift_r;
        tx_s    = tx_r;
        case (state_r)
            BIT_IDLE: begin
                cnt_s = 16'd0;
                if (start) begin
                    state_s = BIT_START;
                    shift_s = data;
                    tx_s    = 1'b0;
                end else begin
                    tx_s = 1'b1;
                end
            end
            BIT_START: begin
                if (bit_end_s) begin
                    state_s = BIT_DATA;
                    cnt_s   = 16'd0;
                    idx_s   = 3'd0;
                    tx_s    = shift_r[0];
                end else begin
                    tx_s = 1'b0;
                end
            end
            BIT_DATA: begin
                if (bit_end_s && (idx_r == 3'd7)) begin
                    state_s = BIT_STOP;
                    cnt_s   = 16'd0;
                    tx_s    = 1'b1;
                end else if (bit_end_s) begin
                    cnt_s = 16'd0;
                    idx_s = idx_r + 3'd1;
                    tx_s  = shift_r[idx_r + 3'd1];
                end else begin
                    tx_s = shift_r[idx_r];
                end
            end
            BIT_STOP: begin
                if (bit_end_s && start) begin
                    state_s = BIT_START;
                    cnt_s   = 16'd0;
                    shift_s = data;
                    tx_s    = 1'b0;
                end else if (bit_end_s) begin
                    state_s = BIT_IDLE;
                    cnt_s   = 16'd0;
                    tx_s    = 1'b1;
                end else begin
                    tx_s = 1'b1;
                end
            end
            default: begin
                state_s = BIT_IDLE;
                cnt_s   = 16'd0;
                tx_s    = 1'b1;
            end
        endcase
    end

    // Bit sequencer registers; the line level is a flop so tx never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= BIT_IDLE;
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
        end
    end

endmodule

// File: rtl/uart_result_tx.sv
// Sends each accepted classification result as a 3-byte packet
// {sync, {train,result}, checksum} over a single UART line.
module uart_result_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 868,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       result_valid,
    input  logic [3:0] result,
    input  logic       train,
    output logic       result_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    pkt_state_e pkt_state_r, pkt_state_s;
    logic [3:0] result_r;
    logic       train_r;
    logic       ready_r, busy_r, busy_s, done_r, done_s;
    logic       hs_s, start_s, byte_done_s;
    logic [7:0] data_s, b1_s;

    assign hs_s         = result_valid && ready_r;
    assign b1_s         = {3'b000, train_r, result_r};
    assign result_ready = ready_r;
    assign busy         = busy_r;
    assign done         = done_r;

    // Packet sequencer: picks the next byte to chain into the serializer
    always_comb begin
        pkt_state_s = pkt_state_r;
        start_s     = 1'b0;
        data_s      = SYNC_BYTE;
        busy_s      = busy_r;
        done_s      = 1'b0;
        case (pkt_state_r)
            PKT_IDLE: begin
                if (hs_s) begin
                    pkt_state_s = PKT_SEND_B0;
                    start_s     = 1'b1;
                    busy_s      = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            PKT_SEND_B0: begin
                if (byte_done_s) begin
                    pkt_state_s = PKT_SEND_B1;
                    start_s     = 1'b1;
                    data_s      = b1_s;
                end else begin
                    data_s = SYNC_BYTE;
                end
            end
            PKT_SEND_B1: begin
                if (byte_done_s) begin
                    pkt_state_s = PKT_SEND_B2;
                    start_s     = 1'b1;
                    data_s      = pkt_checksum(SYNC_BYTE, b1_s);
                end else begin
                    data_s = SYNC_BYTE;
                end
            end
            PKT_SEND_B2: begin
                if (byte_done_s) begin
                    pkt_state_s = PKT_IDLE;
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                pkt_state_s = PKT_IDLE;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Packet state, status flags and the result captured at the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_state_r <= PKT_IDLE;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= 4'd0;
            train_r     <= 1'b0;
        end else begin
            pkt_state_r <= pkt_state_s;
            ready_r     <= (pkt_state_s == PKT_IDLE);
            busy_r      <= busy_s;
            done_r      <= done_s;
            if (hs_s) begin
                result_r <= result;
                train_r  <= train;
            end
        end
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_tx_byte (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .data      (data_s),
        .tx        (tx),
        .byte_done (byte_done_s)
    );

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx: a CLK_DIV=4 instance for packet content,
// timing, hold and reset cases, plus a CLK_DIV=868 instance for full-rate length.
module tb_uart_result_tx;
    import uart_pkg::*;

    localparam int BUSY_CYC = PKT_LEN * 10 * 4;

    logic       clk;
    logic       rst;
    logic       result_valid, result_ready, tx, busy, done, train;
    logic [3:0] result;
    logic       big_valid, big_ready, big_tx, big_busy, big_done;

    int n_checks;
    int n_fails;

    uart_result_tx #(.CLK_DIV(4), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .result       (result),
        .train        (train),
        .result_ready (result_ready),
        .tx           (tx),
        .busy         (busy),
        .done         (done)
    );

    uart_result_tx #(.CLK_DIV(868)) dut_big (
        .clk          (clk),
        .rst          (rst),
        .result_valid (big_valid),
        .result       (4'd0),
        .train        (1'b0),
        .result_ready (big_ready),
        .tx           (big_tx),
        .busy         (big_busy),
        .done         (big_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offers one result and checks the whole 120-cycle waveform that follows.
    task automatic send_pkt(input logic [3:0] res, input logic trn, input logic hold,
                            input logic chg, input logic [7:0] e1, input logic [7:0] e2,
                            input string tag);
        logic [7:0] exp_b [3];
        logic [7:0] got_b [3];
        logic       exp_bit;
        logic       first_tx;
        int         busy_cnt, bad, s;
        exp_b[0] = 8'hA5;
        exp_b[1] = e1;
        exp_b[2] = e2;
        busy_cnt = 0;
        bad      = 0;
        result_valid = 1'b1;
        result       = res;
        train        = trn;
        check_val({tag, ".ready"}, {31'd0, result_ready}, 32'd1);
        @(negedge clk);
        if (!hold) result_valid = 1'b0;
        first_tx = tx;
        for (int i = 0; i < 120; i++) begin
            if (chg && i == 20) result = 4'd2;
            s = (i % 40) / 4;
            if (s == 0) exp_bit = 1'b0;
            else if (s == 9) exp_bit = 1'b1;
            else exp_bit = exp_b[i / 40][s - 1];
            if (tx !== exp_bit) bad++;
            if (done !== 1'b0) bad++;
            if (busy === 1'b1) busy_cnt++;
            if ((i % 4) == 2 && s >= 1 && s <= 8) got_b[i / 40][s - 1] = tx;
            @(negedge clk);
        end
        check_val({tag, ".first_start"}, {31'd0, first_tx}, 32'd0);
        check_val({tag, ".b0"}, {24'd0, got_b[0]}, {24'd0, exp_b[0]});
        check_val({tag, ".b1"}, {24'd0, got_b[1]}, {24'd0, exp_b[1]});
        check_val({tag, ".b2"}, {24'd0, got_b[2]}, {24'd0, exp_b[2]});
        check_val({tag, ".wave_errs"}, bad, 32'd0);
        check_val({tag, ".busy_cycles"}, busy_cnt, BUSY_CYC);
        check_val({tag, ".done"}, {31'd0, done}, 32'd1);
        check_val({tag, ".done_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, ".done_ready"}, {31'd0, result_ready}, 32'd1);
        check_val({tag, ".gap_tx"}, {31'd0, tx}, 32'd1);
        if (!hold) begin
            @(negedge clk);
            check_val({tag, ".done_once"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        logic [29:0] slots;
        int          bad, cnt;
        n_checks     = 0;
        n_fails      = 0;
        rst          = 1'b1;
        result_valid = 1'b0;
        result       = 4'd0;
        train        = 1'b0;
        big_valid    = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst.tx", {31'd0, tx}, 32'd1);
        check_val("rst.ready", {31'd0, result_ready}, 32'd0);
        check_val("rst.busy", {31'd0, busy}, 32'd0);
        check_val("rst.done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst.ready_after", {31'd0, result_ready}, 32'd1);
        @(negedge clk);

        send_pkt(4'd7, 1'b0, 1'b0, 1'b0, 8'h07, 8'hA2, "r7");
        send_pkt(4'd3, 1'b1, 1'b0, 1'b0, 8'h13, 8'hB6, "r3t");
        send_pkt(4'd12, 1'b1, 1'b0, 1'b0, 8'h1C, 8'hB9, "r12t");
        send_pkt(4'd5, 1'b0, 1'b0, 1'b1, 8'h05, 8'hA0, "chg");
        send_pkt(4'd9, 1'b0, 1'b1, 1'b0, 8'h09, 8'hAC, "hold1");
        send_pkt(4'd9, 1'b0, 1'b1, 1'b0, 8'h09, 8'hAC, "hold2");
        result_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("hold.stop", {31'd0, busy}, 32'd0);

        // Abort mid-packet with a reset pulse
        result_valid = 1'b1;
        result       = 4'd7;
        @(negedge clk);
        result_valid = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort.tx", {31'd0, tx}, 32'd1);
        check_val("abort.busy", {31'd0, busy}, 32'd0);
        check_val("abort.done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("abort.ready", {31'd0, result_ready}, 32'd1);
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check_val("abort.quiet", bad, 32'd0);

        // Full-rate divider: one packet of result 0
        check_val("big.ready", {31'd0, big_ready}, 32'd1);
        big_valid = 1'b1;
        @(negedge clk);
        big_valid = 1'b0;
        check_val("big.first_start", {31'd0, big_tx}, 32'd0);
        cnt   = 0;
        slots = 30'd0;
        while (big_busy === 1'b1 && cnt < 30000) begin
            if ((cnt % 868) == 434) slots[cnt / 868] = big_tx;
            cnt++;
            @(negedge clk);
        end
        check_val("big.busy_cycles", cnt, 32'd26040);
        check_val("big.done", {31'd0, big_done}, 32'd1);
        check_val("big.b0", {22'd0, slots[9:0]}, {22'd0, 1'b1, 8'hA5, 1'b0});
        check_val("big.b1", {22'd0, slots[19:10]}, {22'd0, 1'b1, 8'h00, 1'b0});
        check_val("big.b2", {22'd0, slots[29:20]}, {22'd0, 1'b1, 8'hA5, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
